// File: rtl/acc_byte_tx.sv
// Byte-serial transmitter: start/data(LSB first)/stop frame, each bit held CLKS_PER_BIT clocks.
// Optional even-parity bit between data and stop when ACC_TX_PARITY_EN is defined.
module acc_byte_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] PRE  = TW'(CLKS_PER_BIT - 2);

`ifdef ACC_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state;
    logic [TW-1:0]     timer;
    logic [2:0]        idx;
    logic [DATA_W-1:0] shift;
`ifdef ACC_TX_PARITY_EN
    logic              par;
`endif

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // tx_out and done are loaded one edge early so they change exactly on bit boundaries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            timer  <= '0;
            idx    <= '0;
            shift  <= '0;
            tx_out <= 1'b1;
            done   <= 1'b0;
`ifdef ACC_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift  <= in_data;
                        timer  <= '0;
                        idx    <= '0;
                        tx_out <= 1'b0;
                        state  <= START;
`ifdef ACC_TX_PARITY_EN
                        par    <= ^in_data;
`endif
                    end
                end
                START: begin
                    if (timer == LAST) begin
                        timer  <= '0;
                        idx    <= '0;
                        tx_out <= shift[0];
                        state  <= DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == LAST) begin
                        timer <= '0;
                        if (idx == 3'd7) begin
`ifdef ACC_TX_PARITY_EN
                            tx_out <= par;
                            state  <= PARITY;
`else
                            tx_out <= 1'b1;
                            done   <= (CLKS_PER_BIT == 1);
                            state  <= STOP;
`endif
                        end else begin
                            idx    <= idx + 1'b1;
                            shift  <= shift >> 1;
                            tx_out <= shift[1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`ifdef ACC_TX_PARITY_EN
                PARITY: begin
                    if (timer == LAST) begin
                        timer  <= '0;
                        tx_out <= 1'b1;
                        done   <= (CLKS_PER_BIT == 1);
                        state  <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (timer == LAST) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                        done  <= (timer == PRE);
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_byte_tx.sv
// Self-checking bench for acc_byte_tx: one instance at 4 clocks/bit, one at 1 clock/bit.
// Frame length follows ACC_TX_PARITY_EN, the same macro the design uses.
module tb_acc_byte_tx;

`ifdef ACC_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       validA, validB;
    logic       readyA, txA, busyA, doneA;
    logic       readyB, txB, busyB, doneB;

    int total = 0;
    int bad   = 0;
    logic bitQ[$];

    always #5 clk = ~clk;

    acc_byte_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) dutA (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(validA),
        .in_ready(readyA), .tx_out(txA), .busy(busyA), .done(doneA)
    );

    acc_byte_tx #(.CLKS_PER_BIT(1), .DATA_W(8)) dutB (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(validB),
        .in_ready(readyB), .tx_out(txB), .busy(busyB), .done(doneB)
    );

    function automatic logic obsTx(input logic sel);
        return sel ? txB : txA;
    endfunction
    function automatic logic obsBusy(input logic sel);
        return sel ? busyB : busyA;
    endfunction
    function automatic logic obsDone(input logic sel);
        return sel ? doneB : doneA;
    endfunction
    function automatic logic obsReady(input logic sel);
        return sel ? readyB : readyA;
    endfunction

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input logic sel, input string tag);
        checkOutput({tag, "_tx"},    obsTx(sel),    1'b1);
        checkOutput({tag, "_busy"},  obsBusy(sel),  1'b0);
        checkOutput({tag, "_done"},  obsDone(sel),  1'b0);
        checkOutput({tag, "_ready"}, obsReady(sel), 1'b1);
    endtask

    // Called at a negedge; pushes the expected frame, then checks every cycle of it.
    // abortAt > 0 pulls rst_n low in that frame cycle instead of finishing the frame.
    task automatic applyStimulus(input logic sel, input logic [7:0] b, input bit holdValid,
                                 input bit changeMid, input logic [7:0] midVal, input int abortAt);
        int cpb;
        int frameCycles;
        int n;
        logic expBit;
        cpb = sel ? 1 : 4;
        frameCycles = cpb * FRAME_BITS;
        in_data = b;
        if (sel) validB = 1'b1; else validA = 1'b1;
        n = 0;
        while (!obsReady(sel) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_wait", obsReady(sel), 1'b1);
        bitQ.push_back(1'b0);
        for (int i = 0; i < 8; i++) bitQ.push_back(b[i]);
`ifdef ACC_TX_PARITY_EN
        bitQ.push_back(^b);
`endif
        bitQ.push_back(1'b1);
        expBit = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= frameCycles; k++) begin
            @(negedge clk);
            if (k == 1 && !holdValid) begin
                validA = 1'b0;
                validB = 1'b0;
            end
            if (changeMid && k == frameCycles / 2) in_data = midVal;
            if ((k - 1) % cpb == 0 && bitQ.size() > 0) expBit = bitQ.pop_front();
            if (k == abortAt) begin
                rst_n = 1'b0;
                validA = 1'b0;
                validB = 1'b0;
                #1;
                checkIdle(sel, "abort");
                bitQ.delete();
                return;
            end
            checkOutput("frame_tx",    obsTx(sel),    expBit);
            checkOutput("frame_done",  obsDone(sel),  (k == frameCycles));
            checkOutput("frame_busy",  obsBusy(sel),  1'b1);
            checkOutput("frame_ready", obsReady(sel), 1'b0);
        end
        checkOutput("frame_queue_empty", (bitQ.size() == 0), 1'b1);
        @(negedge clk);
        checkIdle(sel, "gap");
    endtask

    initial begin
        rst_n   = 1'b0;
        validA  = 1'b0;
        validB  = 1'b0;
        in_data = 8'h00;
        repeat (3) @(negedge clk);
        checkIdle(1'b0, "in_reset_a");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkIdle(1'b0, "post_reset_a");
            checkIdle(1'b1, "post_reset_b");
        end

        applyStimulus(1'b0, 8'hE0, 1'b0, 1'b0, 8'h00, 0);
        applyStimulus(1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 0);

        applyStimulus(1'b0, 8'h11, 1'b1, 1'b1, 8'h33, 0);
        applyStimulus(1'b0, 8'h22, 1'b0, 1'b0, 8'h00, 0);

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 18);
        repeat (3) begin
            @(negedge clk);
            checkIdle(1'b0, "held_reset");
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkIdle(1'b0, "after_abort");
        applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 0);

        applyStimulus(1'b1, 8'h81, 1'b0, 1'b0, 8'h00, 0);
        applyStimulus(1'b1, 8'h5C, 1'b0, 1'b0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
